// File: rtl/pwm_multichannel_core.sv
// pwm_multichannel_core
//
// Multi-channel PWM generator. Each channel has its own duty cycle. All
// channels share one free-running counter, which a programmable prescaler
// slows down. Duty values are written into a shadow register. They are copied
// into the active register only when the counter wraps, so a PWM period never
// mixes two duty values.
//
// Register map (write-only, byte-wide strobe from the SPI front-end):
//   0x00+k  output-enable byte k   (channels 8k..8k+7)
//   0x10+k  pwm-enable byte k      (channels 8k..8k+7)
//   0x20+i  duty shadow of channel i (low CNT_W bits of the data)
//   0x60    prescaler reload value (low PRESC_W bits of the data)
// Writes to any other address, or to channels that do not exist, are dropped.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   wr_en         one-cycle register write strobe
//   wr_addr       register address (7 bits)
//   wr_data       register write data (8 bits)
//   out           registered channel outputs, one bit per channel
//   period_start  one-cycle pulse in the cycle after each counter wrap

module pwm_multichannel_core #(
   parameter int NUM_CH  = 16,
   parameter int CNT_W   = 8,
   parameter int PRESC_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [6:0]        wr_addr,
   input  logic [7:0]        wr_data,
   output logic [NUM_CH-1:0] out,
   output logic              period_start
);

   localparam logic [CNT_W-1:0] MAX        = '1;
   localparam logic [6:0]       PRESC_ADDR = 7'h60;

   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] presc_cnt;
   logic [CNT_W-1:0]   cnt;
   logic               tick;
   logic               wrap;

   // The prescaler counts down and fires a tick when it reaches zero. The
   // reload value is sampled only at that point. A new prescaler setting
   // therefore never cuts the current tick interval short.
   assign tick = (presc_cnt == '0);
   assign wrap = tick && (cnt == MAX);

   // The prescaler reload register is shared by all channels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (wr_en && (wr_addr == PRESC_ADDR)) begin
         presc <= wr_data[PRESC_W-1:0];
      end
   end

   // This block holds the shared timebase. It contains the prescaler
   // countdown, the PWM counter (which wraps naturally from MAX to 0), and the
   // registered wrap pulse that is presented as period_start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt    <= '0;
         cnt          <= '0;
         period_start <= 1'b0;
      end else begin
         presc_cnt    <= tick ? presc : (presc_cnt - PRESC_W'(1));
         if (tick) begin
            cnt <= cnt + CNT_W'(1);
         end
         period_start <= wrap;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [6:0] EN_OUT_ADDR = 7'(i / 8);
      localparam logic [6:0] EN_PWM_ADDR = 7'(16 + (i / 8));
      localparam logic [6:0] DUTY_ADDR   = 7'(32 + i);

      logic             en_out;
      logic             en_pwm;
      logic [CNT_W-1:0] duty_shadow;
      logic [CNT_W-1:0] duty_active;
      logic             pwm;
      logic             out_q;

      // This block holds the per-channel registers. The active duty value is
      // loaded from the shadow value held before this edge. A shadow write
      // that lands on the wrap edge therefore only takes effect one period
      // later. The enable bits are not double-buffered and act at once.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            en_out      <= 1'b0;
            en_pwm      <= 1'b0;
            duty_shadow <= '0;
            duty_active <= '0;
         end else begin
            if (wrap) begin
               duty_active <= duty_shadow;
            end
            if (wr_en && (wr_addr == EN_OUT_ADDR)) begin
               en_out <= wr_data[i % 8];
            end
            if (wr_en && (wr_addr == EN_PWM_ADDR)) begin
               en_pwm <= wr_data[i % 8];
            end
            if (wr_en && (wr_addr == DUTY_ADDR)) begin
               duty_shadow <= wr_data[CNT_W-1:0];
            end
         end
      end

      // The raw PWM comparison alone could never be high while cnt equals
      // MAX. A duty of MAX is therefore treated as fully on, which makes it a
      // true constant-high output.
      always_comb begin
         pwm = (duty_active == MAX) || (cnt < duty_active);
      end

      // The output is registered so that the pins never glitch. A channel
      // that is enabled but has PWM disabled is driven constantly high.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_q <= 1'b0;
         end else begin
            out_q <= en_out ? (en_pwm ? pwm : 1'b1) : 1'b0;
         end
      end

      assign out[i] = out_q;
   end

endmodule
